// File: rtl/example_pkg.sv
// Shared types and constants for the delta decoder: the decoded step record
// and the two-state sampling FSM.
package example_pkg;

  localparam int REC_W     = 4;
  localparam int REC_GAP_W = 4;

  // Midpoint delta; a step of exactly this size cannot be told apart from its negation.
  localparam logic [REC_W-1:0] HALF = {1'b1, {(REC_W-1){1'b0}}};

  typedef struct packed {
    logic                 dir;
    logic                 amb;
    logic [REC_W-1:0]     mag;
    logic [REC_GAP_W-1:0] gap;
  } delta_rec_t;

  typedef enum logic {PRIME, TRACK} state_t;

endpackage

// File: rtl/example_rec_fifo.sv
// Generic synchronous FIFO with a combinational head read; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module example_rec_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           pop_ok;
  logic           push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr_reg];
  assign level   = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/example_delta_decoder.sv
// Recovers step records (direction, magnitude, idle gap) from successive
// accumulator samples and queues them behind a valid/ready port.
module example_delta_decoder
  import example_pkg::*;
#(
  parameter int W     = REC_W,
  parameter int DEPTH = 4,
  parameter int GAP_W = REC_GAP_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [W-1:0]           acc,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_dir,
  output logic [W-1:0]           m_mag,
  output logic [GAP_W-1:0]       m_gap,
  output logic                   m_amb,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  input  logic                   clr_ovf
);

  state_t           state_reg, state_next;
  logic [W-1:0]     prev_reg, prev_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             ovf_reg;
  logic [W-1:0]     d;
  logic             rec_push;
  delta_rec_t       rec;
  delta_rec_t       head;
  logic             full;
  logic             empty;
  logic             pop_fire;
  logic             drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= PRIME;
      prev_reg  <= '0;
      gap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      gap_reg   <= gap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    gap_next   = gap_reg;
    rec_push   = 1'b0;
    rec        = '0;
    d          = acc - prev_reg;
    if (en) begin
      prev_next = acc;
      case (state_reg)
        PRIME: state_next = TRACK;
        TRACK: begin
          if (d == '0) begin
            if (gap_reg != '1) gap_next = gap_reg + GAP_W'(1);
          end else begin
            rec_push = 1'b1;
            gap_next = '0;
            rec.gap  = gap_reg;
            // Deltas above the midpoint are decrements in modular terms.
            if (d > HALF) begin
              rec.dir = 1'b0;
              rec.mag = '0 - d;
            end else begin
              rec.dir = 1'b1;
              rec.mag = d;
              rec.amb = (d == HALF);
            end
          end
        end
        default: state_next = PRIME;
      endcase
    end
  end

  example_rec_fifo #(
    .DEPTH (DEPTH),
    .T     (delta_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rec_push),
    .push_data (rec),
    .pop       (pop_fire),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign m_valid  = !empty;
  assign pop_fire = m_valid && m_ready;
  assign drop     = rec_push && full && !pop_fire;

  // Fields read as zero while empty so the reset state is well defined.
  assign m_dir = m_valid ? head.dir : 1'b0;
  assign m_amb = m_valid ? head.amb : 1'b0;
  assign m_mag = m_valid ? head.mag : '0;
  assign m_gap = m_valid ? head.gap : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_reg <= 1'b0;
    else if (drop)    ovf_reg <= 1'b1;
    else if (clr_ovf) ovf_reg <= 1'b0;
  end

  assign ovf = ovf_reg;

endmodule

// File: tb/tb_example_delta_decoder.sv
// Directed bench for example_delta_decoder: linear steps with hand-computed
// expected records, checked by immediate assertions.
module tb_example_delta_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] acc;
  logic       m_valid;
  logic       m_ready;
  logic       m_dir;
  logic [3:0] m_mag;
  logic [3:0] m_gap;
  logic       m_amb;
  logic [2:0] level;
  logic       ovf;
  logic       clr_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  example_delta_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .acc     (acc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_dir   (m_dir),
    .m_mag   (m_mag),
    .m_gap   (m_gap),
    .m_amb   (m_amb),
    .level   (level),
    .ovf     (ovf),
    .clr_ovf (clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int dir, input int mag, input int gap, input int amb);
    chk({tag, ".valid"}, 32'(m_valid), 32'd1);
    chk({tag, ".dir"},   32'(m_dir),   32'(dir));
    chk({tag, ".mag"},   32'(m_mag),   32'(mag));
    chk({tag, ".gap"},   32'(m_gap),   32'(gap));
    chk({tag, ".amb"},   32'(m_amb),   32'(amb));
    $display("[TB] %s: dir=%0d mag=%0d gap=%0d amb=%0d level=%0d", tag, m_dir, m_mag, m_gap, m_amb, level);
  endtask

  // One enabled (or idle) sample, then en drops so idle cycles never count.
  task automatic step(input logic e, input logic [3:0] a);
    en  = e;
    acc = a;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; acc = '0; m_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(m_valid), 32'd0);
    chk("rst.level", 32'(level), 32'd0);
    chk("rst.ovf",   32'(ovf), 32'd0);
    chk("rst.mag",   32'(m_mag), 32'd0);
    chk("rst.gap",   32'(m_gap), 32'd0);
    chk("rst.dir",   32'(m_dir), 32'd0);
    rst_n = 1'b1;

    // Prime on 3, then 3 -> 7 is +4.
    step(1'b1, 4'd3);
    chk("prime.valid", 32'(m_valid), 32'd0);
    step(1'b1, 4'd7);
    chk_rec("up4", 1, 4, 0, 0);
    chk("up4.level", 32'(level), 32'd1);
    pop_one();
    chk("pop.level", 32'(level), 32'd0);

    // Two zero-change samples, a disabled cycle that must not count, then 7 -> 2 is -5.
    step(1'b1, 4'd7);
    step(1'b1, 4'd7);
    step(1'b0, 4'd9);
    step(1'b1, 4'd2);
    chk_rec("dn5", 0, 5, 2, 0);
    pop_one();

    // 2 -> 14 is -4; wrap 14 -> 1 is +3; 1 -> 9 is the ambiguous midpoint.
    step(1'b1, 4'd14);
    chk_rec("dn4", 0, 4, 0, 0);
    pop_one();
    step(1'b1, 4'd1);
    chk_rec("wrap3", 1, 3, 0, 0);
    pop_one();
    step(1'b1, 4'd9);
    chk_rec("amb8", 1, 8, 0, 1);
    pop_one();

    // Gap saturates at 15 after 20 idle samples.
    for (int i = 0; i < 20; i++) step(1'b1, 4'd9);
    step(1'b1, 4'd10);
    chk_rec("gapsat", 1, 1, 15, 0);
    pop_one();

    // Five changes with no consumer: fifth is dropped.
    step(1'b1, 4'd11);
    step(1'b1, 4'd13);
    step(1'b1, 4'd10);
    step(1'b1, 4'd6);
    chk("fill.level", 32'(level), 32'd4);
    chk("fill.ovf",   32'(ovf), 32'd0);
    step(1'b1, 4'd7);
    chk("ovf.level", 32'(level), 32'd4);
    chk("ovf.flag",  32'(ovf), 32'd1);
    chk_rec("ovf.q0", 1, 1, 0, 0);
    pop_one();
    chk_rec("ovf.q1", 1, 2, 0, 0);
    pop_one();
    chk_rec("ovf.q2", 0, 3, 0, 0);
    pop_one();
    chk_rec("ovf.q3", 0, 4, 0, 0);
    pop_one();
    chk("drain.valid", 32'(m_valid), 32'd0);
    chk("drain.ovf",   32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    step(1'b0, 4'd0);
    clr_ovf = 1'b0;
    chk("clr.ovf", 32'(ovf), 32'd0);

    // Full FIFO with simultaneous pop and push (prev = 7).
    step(1'b1, 4'd8);
    step(1'b1, 4'd10);
    step(1'b1, 4'd12);
    step(1'b1, 4'd15);
    chk("full.level", 32'(level), 32'd4);
    m_ready = 1'b1;
    step(1'b1, 4'd0);
    m_ready = 1'b0;
    chk("pp.level", 32'(level), 32'd4);
    chk("pp.ovf",   32'(ovf), 32'd0);
    chk_rec("pp.q0", 1, 2, 0, 0);
    pop_one();
    chk_rec("pp.q1", 1, 2, 0, 0);
    pop_one();
    chk_rec("pp.q2", 1, 3, 0, 0);
    pop_one();
    chk_rec("pp.tail", 1, 1, 0, 0);
    pop_one();

    // Overflow beats a same-cycle clear (prev = 0).
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    step(1'b1, 4'd3);
    step(1'b1, 4'd4);
    clr_ovf = 1'b1;
    step(1'b1, 4'd5);
    chk("ovfwin.ovf", 32'(ovf), 32'd1);
    step(1'b0, 4'd0);
    clr_ovf = 1'b0;
    chk("ovfclr.ovf", 32'(ovf), 32'd0);
    pop_one();
    chk("pre_rst.level", 32'(level), 32'd3);

    // Asynchronous reset between clock edges with three records queued.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(m_valid), 32'd0);
    chk("arst.level", 32'(level), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'd5);
    chk("reprime.valid", 32'(m_valid), 32'd0);
    chk("reprime.level", 32'(level), 32'd0);
    step(1'b1, 4'd6);
    chk_rec("post_rst", 1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
